// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-memory fetch controller
// and the range checker it reuses.
package imem_fetch_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_W     = 32;
  localparam int BYTE_W      = 8;
  localparam int INSTR_BYTES = INSTR_W / BYTE_W;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_slot_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_range_chk.sv
// Alignment and upper-bound check for an ACCESS_BYTES-wide access into a
// MEM_BYTES memory; bad is high when the access must not be performed.
module imem_fetch_ctrl_range_chk
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int MEM_BYTES    = 32,
  parameter int ACCESS_BYTES = 4
) (
  input  logic [XLEN-1:0] addr,
  output logic            bad
);

  localparam logic [XLEN-1:0] LAST_OK    = XLEN'(MEM_BYTES - ACCESS_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ACCESS_BYTES - 1);

  logic misaligned;
  logic out_of_range;

  // Comparing against the last legal base avoids computing addr+size,
  // so no overflow handling is needed at the top of the address space.
  always_comb begin
    misaligned   = |(addr & ALIGN_MASK);
    out_of_range = addr > LAST_OK;
    bad          = misaligned | out_of_range;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Program counter, boot-time byte loader arbitration and one-deep fetch
// register toward decode, with a sticky fault on illegal fetch/load.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int              MEM_BYTES = 32,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               boot_en,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [XLEN-1:0]    ld_addr,
  input  logic [BYTE_W-1:0]  ld_data,
  output logic [XLEN-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_waddr,
  output logic [BYTE_W-1:0]  mem_wdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  fetch_slot_t     slot_q, slot_d;
  logic            if_valid_q, if_valid_d;
  logic            fault_q, fault_d;

  logic fetch_bad;
  logic ld_bad;
  logic fetch_en;

  imem_fetch_ctrl_range_chk #(
    .MEM_BYTES   (MEM_BYTES),
    .ACCESS_BYTES(INSTR_BYTES)
  ) u_fetch_chk (
    .addr(pc_q),
    .bad (fetch_bad)
  );

  imem_fetch_ctrl_range_chk #(
    .MEM_BYTES   (MEM_BYTES),
    .ACCESS_BYTES(1)
  ) u_ld_chk (
    .addr(ld_addr),
    .bad (ld_bad)
  );

  // Redirect outranks fetch; a bad target is only caught when it is fetched.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    slot_d     = slot_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    fetch_en   = !if_valid_q || if_ready;

    unique case (state_q)
      ST_IDLE: begin
        state_d = boot_en ? ST_LOAD : ST_RUN;
        pc_d    = RESET_PC;
      end

      ST_LOAD: begin
        ld_ready = boot_en;
        if (ld_valid && boot_en) begin
          if (ld_bad) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end else if (!boot_en) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_d       = redirect_pc;
        end else if (fetch_en) begin
          if (fetch_bad) begin
            state_d    = ST_FAULT;
            fault_d    = 1'b1;
            if_valid_d = 1'b0;
          end else begin
            slot_d     = '{pc: pc_q, instr: mem_rdata};
            if_valid_d = 1'b1;
            pc_d       = next_pc(pc_q);
          end
        end
      end

      ST_FAULT: begin
        fault_d    = 1'b1;
        if_valid_d = 1'b0;
      end

      default: begin
        state_d    = ST_FAULT;
        fault_d    = 1'b1;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      slot_q     <= '0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      slot_q     <= slot_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_addr  = pc_q;
  assign mem_waddr = ld_addr;
  assign mem_wdata = ld_data;
  assign if_valid  = if_valid_q;
  assign if_pc     = slot_q.pc;
  assign if_instr  = slot_q.instr;
  assign fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed vector table, loader and
// fault sequences, then randomized run traffic against a queue-based model.
module tb_imem_fetch_ctrl;
  import imem_fetch_ctrl_pkg::*;

  localparam int MEM_BYTES = 32;
  localparam logic [31:0] PROGRAM [8] = '{
    32'hFFC4A303, 32'h00A00093, 32'h0062E233, 32'h00108093,
    32'h00200113, 32'h00310193, 32'h00420213, 32'h00528293
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_en = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .boot_en(boot_en),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .fault(fault)
  );

  // Behavioural instruction memory: preload on request, byte writes from the DUT.
  logic [7:0] tb_mem [MEM_BYTES];
  logic       preload_req = 1'b0;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int w = 0; w < 8; w++)
        for (int b = 0; b < 4; b++)
          tb_mem[w*4+b] <= PROGRAM[w][b*8 +: 8];
    end else if (mem_we && mem_waddr < MEM_BYTES) begin
      tb_mem[mem_waddr[4:0]] <= mem_wdata;
    end
  end

  function automatic logic [31:0] read_word(input logic [31:0] a);
    logic [4:0] i;
    i = a[4:0];
    if (a <= 32'(MEM_BYTES - 4))
      return {tb_mem[i+5'd3], tb_mem[i+5'd2], tb_mem[i+5'd1], tb_mem[i]};
    return 32'hDEADBEEF;
  endfunction

  always_comb mem_rdata = read_word(mem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc,
                               input logic boot, input logic ldv, input logic [31:0] lda,
                               input logic [7:0] ldd);
    @(negedge clk);
    if_ready       = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    boot_en        = boot;
    ld_valid       = ldv;
    ld_addr        = lda;
    ld_data        = ldd;
    #1;
  endtask

  task automatic reset_dut(input logic boot, input logic preload);
    @(negedge clk);
    rst_n = 1'b0;
    boot_en = boot;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_ld_ready", 32'(ld_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    preload_req = preload;
    @(posedge clk);
    #1 preload_req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_fault;
    logic        chk_addr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic f, input logic ca, input logic [31:0] addr);
    vecs.push_back('{r, rv, rpc, v, pc, instr, f, ca, addr});
  endtask

  // Reference model: the fetch stage as a queue of at most one {pc, instr}.
  fetch_slot_t model_q[$];
  longint      model_pc;
  bit          model_fault;
  bit          model_idle;

  task automatic model_reset();
    model_q.delete();
    model_pc    = 0;
    model_fault = 0;
    model_idle  = 1;
  endtask

  task automatic model_step(input logic ready, input logic redir, input logic [31:0] rpc);
    if (model_idle) begin
      model_idle = 0;
    end else if (model_fault) begin
      model_q.delete();
    end else if (redir) begin
      model_q.delete();
      model_pc = rpc;
    end else if (model_q.size() == 0 || ready) begin
      if (model_q.size() != 0) void'(model_q.pop_front());
      if (model_pc % 4 != 0 || model_pc + 4 > MEM_BYTES) begin
        model_fault = 1;
        model_q.delete();
      end else begin
        model_q.push_back('{pc: 32'(model_pc), instr: read_word(32'(model_pc))});
        model_pc += 4;
      end
    end
  endtask

  initial begin
    logic [7:0] ld_bytes [4];
    int we_count;
    int fault_age;
    logic ready, redir, boot;
    logic [31:0] rpc;

    $display("[TB] start");

    add_vec(1, 0, 0,     0, 0,     0,            0, 1, 32'h00);
    add_vec(1, 0, 0,     0, 0,     0,            0, 1, 32'h00);
    add_vec(1, 0, 0,     1, 32'h0, 32'hFFC4A303, 0, 1, 32'h04);
    add_vec(1, 0, 0,     1, 32'h4, 32'h00A00093, 0, 1, 32'h08);
    add_vec(0, 0, 0,     1, 32'h8, 32'h0062E233, 0, 1, 32'h0C);
    add_vec(0, 0, 0,     1, 32'h8, 32'h0062E233, 0, 1, 32'h0C);
    add_vec(0, 0, 0,     1, 32'h8, 32'h0062E233, 0, 1, 32'h0C);
    add_vec(1, 1, 32'h10, 1, 32'h8, 32'h0062E233, 0, 1, 32'h0C);
    add_vec(1, 0, 0,     0, 0,     0,            0, 1, 32'h10);
    add_vec(1, 0, 0,     1, 32'h10, 32'h00200113, 0, 1, 32'h14);
    add_vec(1, 0, 0,     1, 32'h14, 32'h00310193, 0, 1, 32'h18);
    add_vec(1, 0, 0,     1, 32'h18, 32'h00420213, 0, 1, 32'h1C);
    add_vec(1, 0, 0,     1, 32'h1C, 32'h00528293, 0, 1, 32'h20);
    add_vec(1, 0, 0,     0, 0,     0,            1, 0, 0);
    add_vec(1, 0, 0,     0, 0,     0,            1, 0, 0);

    reset_dut(1'b0, 1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ready, vecs[i].redir, vecs[i].rpc, 1'b0, 1'b1, 32'h3, 8'hAA);
      checkOutput($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      checkOutput($sformatf("vec%0d_ld_ready", i), 32'(ld_ready), 32'd0);
      checkOutput($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'd0);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_instr);
      end
      if (vecs[i].chk_addr)
        checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
    end

    // Boot loader: four bytes with one idle gap, then hand over to RUN.
    ld_bytes = '{8'h13, 8'h00, 8'h50, 8'h00};
    we_count = 0;
    reset_dut(1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1'b1, 1'b0, 0, 0);
    checkOutput("idle_ld_ready", 32'(ld_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        applyStimulus(0, 0, 0, 1'b1, 1'b0, 32'h9, 8'hEE);
        checkOutput("ld_gap_we", 32'(mem_we), 32'd0);
        checkOutput("ld_gap_ready", 32'(ld_ready), 32'd1);
      end else begin
        automatic int idx = (k > 2) ? k - 1 : k;
        applyStimulus(0, 0, 0, 1'b1, 1'b1, 32'(idx), ld_bytes[idx]);
        checkOutput("ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("ld_we", 32'(mem_we), 32'd1);
        checkOutput("ld_waddr", mem_waddr, 32'(idx));
        checkOutput("ld_wdata", 32'(mem_wdata), 32'(ld_bytes[idx]));
      end
      if (mem_we) we_count++;
    end
    applyStimulus(1, 0, 0, 1'b0, 1'b1, 32'h4, 8'h77);
    checkOutput("ld_exit_ready", 32'(ld_ready), 32'd0);
    checkOutput("ld_exit_we", 32'(mem_we), 32'd0);
    if (mem_we) we_count++;
    checkOutput("ld_we_pulses", 32'(we_count), 32'd4);
    applyStimulus(1, 0, 0, 1'b1, 1'b1, 32'h5, 8'h66);
    checkOutput("run1_valid", 32'(if_valid), 32'd0);
    checkOutput("run1_mem_addr", mem_addr, 32'h0);
    checkOutput("run1_ld_ready", 32'(ld_ready), 32'd0);
    checkOutput("run1_mem_we", 32'(mem_we), 32'd0);
    applyStimulus(1, 0, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("run2_valid", 32'(if_valid), 32'd1);
    checkOutput("run2_pc", if_pc, 32'h0);
    checkOutput("run2_instr", if_instr, 32'h00500013);

    // Misaligned redirect target faults when it is fetched and stays sticky.
    reset_dut(1'b0, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h2, 0, 0, 0, 0);
    checkOutput("mis_pre_valid", 32'(if_valid), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("mis_n1_valid", 32'(if_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1'(k & 1), 32'h8, 1'b1, 1'b1, 32'h1, 8'h11);
      checkOutput("mis_fault", 32'(fault), 32'd1);
      checkOutput("mis_valid", 32'(if_valid), 32'd0);
      checkOutput("mis_ld_ready", 32'(ld_ready), 32'd0);
      checkOutput("mis_mem_we", 32'(mem_we), 32'd0);
    end

    // Loader byte beyond the memory: no write, then sticky fault.
    reset_dut(1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1'b1, 1'b0, 0, 0);
    applyStimulus(0, 0, 0, 1'b1, 1'b1, 32'd32, 8'h55);
    checkOutput("ldoor_ready", 32'(ld_ready), 32'd1);
    checkOutput("ldoor_we", 32'(mem_we), 32'd0);
    checkOutput("ldoor_pre_fault", 32'(fault), 32'd0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 1'b1, 1'b1, 32'h5, 8'h55);
      checkOutput("ldoor_fault", 32'(fault), 32'd1);
      checkOutput("ldoor_post_ready", 32'(ld_ready), 32'd0);
      checkOutput("ldoor_post_we", 32'(mem_we), 32'd0);
    end

    // Randomized run traffic against the reference model.
    reset_dut(1'b0, 1'b1);
    model_reset();
    fault_age = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 7) == 0);
      rpc   = 32'($urandom_range(0, 8) * 4);
      if ($urandom_range(0, 15) == 0) rpc = rpc + 32'd2;
      boot  = model_idle ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus(ready, redir, rpc, boot, 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 40)), 8'($urandom_range(0, 255)));
      checkOutput("rnd_valid", 32'(if_valid), 32'(model_q.size() != 0));
      checkOutput("rnd_fault", 32'(fault), 32'(model_fault));
      checkOutput("rnd_ld_ready", 32'(ld_ready), 32'd0);
      checkOutput("rnd_mem_we", 32'(mem_we), 32'd0);
      if (model_q.size() != 0) begin
        checkOutput("rnd_pc", if_pc, model_q[0].pc);
        checkOutput("rnd_instr", if_instr, model_q[0].instr);
      end
      if (!model_fault)
        checkOutput("rnd_mem_addr", mem_addr, 32'(model_pc));
      model_step(ready, redir, rpc);
      fault_age = model_fault ? fault_age + 1 : 0;
      if (fault_age > 3) begin
        reset_dut(1'b0, 1'b0);
        model_reset();
        fault_age = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
